// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants for the stopwatch tick generator.
//   CNT_W_DEF  default counter/divisor width
//   CLK_HZ     board clock frequency
//   DIV_*      divisors producing 1 Hz, 2 Hz and 500 Hz from CLK_HZ
//   cnt_t      counter type at the default width
package tick_gen_pkg;
    localparam int CNT_W_DEF = 27;
    localparam int CLK_HZ    = 100_000_000;
    localparam int DIV_1HZ   = 100_000_000;
    localparam int DIV_2HZ   = 50_000_000;
    localparam int DIV_500HZ = 200_000;

    typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one tick channel. It holds a free-running period counter, the
// active divisor and a shadow divisor that is swapped in only at a period
// boundary, so a period is never truncated or stretched.
// Optional feature macro: TICK_GEN_SQUARE_EN adds a 50 % square-wave output.
// Ports:
//   i_clk_in   clock
//   i_rst      synchronous active-high reset
//   i_adv      channel advances this cycle (global & per-channel enable)
//   i_sync     restart the period, apply any pending divisor now
//   i_wr       validated divisor write for this channel
//   i_wr_val   new divisor (never 0 when i_wr is high)
//   o_tick     registered one-cycle pulse at the end of each period
//   o_pend     a written divisor is waiting for the next period boundary
//   o_sq       toggles on every tick (TICK_GEN_SQUARE_EN only)
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int             CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(1)
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic             i_adv,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_val,
`ifdef TICK_GEN_SQUARE_EN
    output logic             o_sq,
`endif
    output logic             o_tick,
    output logic             o_pend
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_nxt;
    logic             r_pend;
    logic             r_tick;
    logic             w_term;

    // r_div_act is never 0, so the subtraction cannot wrap.
    assign w_term = (r_cnt == r_div_act - CNT_W'(1));

    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_div_act <= DIV_INIT;
            r_div_nxt <= '0;
            r_pend    <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_sync) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_pend <= 1'b0;
            // A write coinciding with sync is newer than anything pending.
            if (i_wr) begin
                r_div_act <= i_wr_val;
                r_div_nxt <= i_wr_val;
            end else if (r_pend) begin
                r_div_act <= r_div_nxt;
            end
        end else begin
            if (i_adv && w_term) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                if (r_pend) begin
                    r_div_act <= r_div_nxt;
                    r_pend    <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
                if (i_adv) r_cnt <= r_cnt + CNT_W'(1);
            end
            // Placed last so a write on the terminal cycle re-arms pend after
            // the old shadow value has been consumed above.
            if (i_wr) begin
                r_div_nxt <= i_wr_val;
                r_pend    <= 1'b1;
            end
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    logic r_sq;
    always_ff @(posedge i_clk_in) begin
        if (i_rst || i_sync)    r_sq <= 1'b0;
        else if (i_adv && w_term) r_sq <= ~r_sq;
    end
    assign o_sq = r_sq;
`endif

    assign o_tick = r_tick;
    assign o_pend = r_pend;
endmodule

// File: rtl/tick_gen.sv
// tick_gen: NUM_CH independent, runtime-programmable tick channels.
// Optional feature macro: TICK_GEN_SQUARE_EN adds the o_sq port.
// Ports:
//   i_clk_in   100 MHz system clock
//   i_rst      synchronous active-high reset
//   i_clk_en   global count enable
//   i_ch_en    per-channel count enable
//   i_sync     restart all channels in phase
//   i_div_wr   divisor write strobe
//   i_div_sel  channel addressed by the write
//   i_div_val  new divisor; 0 or an out-of-range channel is ignored
//   o_tick     one-cycle pulse per period, per channel
//   o_pend     divisor written but not yet applied, per channel
//   o_sq       50 % square wave per channel (TICK_GEN_SQUARE_EN only)
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_RST =
        {CNT_W'(DIV_1HZ), CNT_W'(DIV_2HZ), CNT_W'(DIV_500HZ)},
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk_in,
    input  logic              i_rst,
    input  logic              i_clk_en,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic              i_sync,
    input  logic              i_div_wr,
    input  logic [SEL_W-1:0]  i_div_sel,
    input  logic [CNT_W-1:0]  i_div_val,
`ifdef TICK_GEN_SQUARE_EN
    output logic [NUM_CH-1:0] o_sq,
`endif
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_pend
);
    logic [NUM_CH-1:0] w_adv;
    logic [NUM_CH-1:0] w_wr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_adv[g] = i_clk_en & i_ch_en[g];
        // Out-of-range selects never match any g, so they drop out here.
        assign w_wr[g]  = i_div_wr && (i_div_val != '0) && (i_div_sel == SEL_W'(g));

        tick_gen_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_RST[g*CNT_W +: CNT_W])
        ) u_ch (
            .i_clk_in (i_clk_in),
            .i_rst    (i_rst),
            .i_adv    (w_adv[g]),
            .i_sync   (i_sync),
            .i_wr     (w_wr[g]),
            .i_wr_val (i_div_val),
`ifdef TICK_GEN_SQUARE_EN
            .o_sq     (o_sq[g]),
`endif
            .o_tick   (o_tick[g]),
            .o_pend   (o_pend[g])
        );
    end
endmodule

// File: tb/tb_tick_gen.sv
module tb_tick_gen;
    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DR [NCH] = '{4, 6, 10};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clk_en = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic           sync = 1'b0;
    logic           wr = 1'b0;
    logic [1:0]     sel = '0;
    logic [CW-1:0]  val = '0;
    logic [NCH-1:0] tick, pend;
`ifdef TICK_GEN_SQUARE_EN
    logic [NCH-1:0] sq;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: per channel, enabled edges elapsed in the current
    // period, the period length, and a queued period length.
    int m_el [NCH];
    int m_d  [NCH];
    int m_nx [NCH];
    bit m_pd [NCH];
    bit m_tk [NCH];
    bit m_sq [NCH];

    always #5 clk = ~clk;

    tick_gen #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DIV_RST ({8'd10, 8'd6, 8'd4})
    ) dut (
        .i_clk_in  (clk),
        .i_rst     (rst),
        .i_clk_en  (clk_en),
        .i_ch_en   (ch_en),
        .i_sync    (sync),
        .i_div_wr  (wr),
        .i_div_sel (sel),
        .i_div_val (val),
`ifdef TICK_GEN_SQUARE_EN
        .o_sq      (sq),
`endif
        .o_tick    (tick),
        .o_pend    (pend)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit ok;
        ok = wr && (val != 0) && (sel < NCH);
        for (int c = 0; c < NCH; c++) begin
            bit w;
            w = ok && (int'(sel) == c);
            if (rst) begin
                m_el[c] = 0; m_d[c] = DR[c]; m_nx[c] = 0;
                m_pd[c] = 0; m_tk[c] = 0; m_sq[c] = 0;
            end else if (sync) begin
                m_el[c] = 0; m_tk[c] = 0; m_sq[c] = 0;
                if (w) m_d[c] = int'(val);
                else if (m_pd[c]) m_d[c] = m_nx[c];
                if (w) m_nx[c] = int'(val);
                m_pd[c] = 0;
            end else begin
                m_tk[c] = 0;
                if (clk_en && ch_en[c]) begin
                    m_el[c]++;
                    if (m_el[c] == m_d[c]) begin
                        m_tk[c] = 1; m_el[c] = 0; m_sq[c] = !m_sq[c];
                        if (m_pd[c]) begin m_d[c] = m_nx[c]; m_pd[c] = 0; end
                    end
                end
                if (w) begin m_nx[c] = int'(val); m_pd[c] = 1; end
            end
        end
    endtask

    // One clock: update the model with the inputs the DUT sees, then compare.
    task automatic step();
        logic [NCH-1:0] et, ep, es;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < NCH; c++) begin
            et[c] = m_tk[c]; ep[c] = m_pd[c]; es[c] = m_sq[c];
        end
        chk("model_tick", tick, et);
        chk("model_pend", pend, ep);
`ifdef TICK_GEN_SQUARE_EN
        chk("model_sq", sq, es);
`else
        es = '0;
`endif
    endtask

    task automatic reset_all();
        rst = 1'b1; sync = 1'b0; wr = 1'b0; clk_en = 1'b1; ch_en = '1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        step(); step();
        chk("rst_tick", tick, 0);
        chk("rst_pend", pend, 0);

        // Base periods 4/6/10 from reset.
        clk_en = 1'b1; ch_en = '1; rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            step();
            chk("base_tick", tick, {e % 10 == 0, e % 6 == 0, e % 4 == 0});
            chk("base_pend", pend, 0);
        end

        // Write 7 to ch0 mid-period: current period completes at edge 4.
        reset_all();
        step();
        wr = 1'b1; sel = 2'd0; val = 8'd7;
        step();
        wr = 1'b0;
        chk("wr_pend_rise", pend[0], 1);
        for (int e = 3; e <= 20; e++) begin
            step();
            chk("wr_tick0", tick[0], (e == 4 || e == 11 || e == 18));
            if (e == 4) chk("wr_pend_fall", pend[0], 0);
        end

        // clk_en low for 5 cycles after two enabled edges delays by 5.
        reset_all();
        for (int i = 0; i <= 12; i++) begin
            clk_en = !(i >= 2 && i < 7);
            step();
            chk("pause_tick0", tick[0], (i == 8 || i == 12));
        end
        clk_en = 1'b1;

        // Two writes (5, then 9) then sync: 9 applies at once.
        reset_all();
        step();
        wr = 1'b1; sel = 2'd0; val = 8'd5; step();
        val = 8'd9; step();
        wr = 1'b0; sync = 1'b1; step();
        sync = 1'b0;
        chk("sync_pend", pend, 0);
        chk("sync_tick", tick, 0);
        for (int i = 1; i <= 18; i++) begin
            step();
            chk("sync_ticks", tick, {i % 10 == 0, i % 6 == 0, (i == 9 || i == 18)});
        end

        // Ignored writes: divisor 0 and channel 3.
        wr = 1'b1; sel = 2'd0; val = 8'd0; step();
        sel = 2'd3; val = 8'd5; step();
        wr = 1'b0;
        chk("bad_wr_pend", pend, 0);

        // Divisor 1 on ch1 via write during sync: tick every enabled cycle.
        wr = 1'b1; sel = 2'd1; val = 8'd1; sync = 1'b1; step();
        wr = 1'b0; sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("div1_tick1", tick[1], 1);
        end

`ifdef TICK_GEN_SQUARE_EN
        // D=3: sq high for 3 edges, low for 3; rst mid-high clears it.
        wr = 1'b1; sel = 2'd0; val = 8'd3; sync = 1'b1; step();
        wr = 1'b0; sync = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("sq0", sq[0], (i / 3) % 2);
        end
        rst = 1'b1; step(); rst = 1'b0;
        chk("sq_rst", sq, 0);
        chk("sq_rst_tick", tick, 0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            sync   = ($urandom_range(0, 39) == 0);
            clk_en = ($urandom_range(0, 7) != 0);
            ch_en  = NCH'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ch_en = '1;
            wr     = ($urandom_range(0, 7) == 0);
            sel    = 2'($urandom_range(0, 3));
            val    = 8'($urandom_range(0, 9));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
